edge_debounce_capture: RTL and testbench
========================================

EDGE_DEBOUNCE_CAPTURE -- requirements
Module: edge_debounce_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a level change; legal values are 2..255.
REQ-002 SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-003 SHALL have parameter TS_W, default 16: width of the timestamp.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sig_in, input, 1 bit: raw, asynchronous level to monitor.
REQ-007 SHALL have port evt_valid, output, 1 bit: a debounced edge event is pending.
REQ-008 SHALL have port evt_ready, input, 1 bit: the consumer accepts the event.
REQ-009 SHALL have port evt_type, output, 1 bit: 1 = rise, 0 = fall.
REQ-010 SHALL have port evt_ts, output, TS_W bits: timestamp of the event (only when EDGE_TIMESTAMP_EN is defined).
REQ-011 SHALL have port event_count, output, CNT_W bits: count of accepted events.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, an event was dropped.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-014 SHALL pass sig_in through a two-stage previous chain: p1_sig <= sig_in, p2_sig <= p1_sig. The FSM reads only p2_sig.
REQ-015 SHALL implement the FSM with four states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-016 In LOW, when p2_sig=1, the FSM SHALL go to RISE_CHK and set deb_cnt to 1.
REQ-017 In RISE_CHK:
- p2_sig=0: return to LOW, clear deb_cnt, no event.
- p2_sig=1 and deb_cnt=DEBOUNCE_CYCLES-1: go to HIGH and pulse a rise event for one cycle.
- otherwise: increment deb_cnt.
REQ-018 HIGH and FALL_CHK SHALL behave as the mirror of REQ-016/017, producing a fall event.
REQ-019 Latency: if sig_in is first sampled high at edge N and stays high, the rise event SHALL be visible in the cycle after edge N+DEBOUNCE_CYCLES+1.
REQ-020 Event register: on an event, if evt_valid=0, or evt_valid=1 and evt_ready=1 in the same cycle, the block SHALL load evt_type (and evt_ts), assert evt_valid and increment event_count.
REQ-021 event_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 If evt_valid=1 and evt_ready=0 when an event occurs, the new event SHALL be dropped, ovf set, and the pending event left unchanged.
REQ-023 While evt_valid=1, evt_type and evt_ts SHALL stay stable until the cycle of the evt_ready handshake.
REQ-024 evt_ready with no new event SHALL clear evt_valid on the next edge.
REQ-025 ovf SHALL clear on ovf_clr=1; if a set and a clear occur in the same cycle, the set wins.

Reset
REQ-026 On reset assertion, the block SHALL immediately force:
- p1_sig, p2_sig = 0
- state = LOW, deb_cnt = 0
- evt_valid = 0, evt_type = 0, evt_ts = 0
- event_count = 0, ovf = 0, timestamp counter = 0
REQ-027 Reset asserted during RISE_CHK or FALL_CHK SHALL abort the check with no event emitted. After release, a held-high sig_in SHALL be re-qualified from LOW.

Configuration
REQ-028 With EDGE_TIMESTAMP_EN defined, the block SHALL include:
- a free-running TS_W-bit counter that increments every cycle and wraps from 2^TS_W-1 to 0;
- an evt_ts port that captures the counter value of the event cycle.
REQ-029 Without EDGE_TIMESTAMP_EN, the timestamp counter and the evt_ts port SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 The shared package edge_pkg SHALL hold:
- the state enum (LOW, RISE_CHK, HIGH, FALL_CHK);
- constants EDGE_RISE=1 and EDGE_FALL=0.
REQ-031 The two-stage previous chain SHALL be the sub-module edge_prev_sync, instantiated once.

Verification
REQ-032 DEBOUNCE_CYCLES=4, sig_in 0->1 held, evt_ready=1 -> exactly one rise event 6 edges after first sampling; evt_type=1; event_count=1.
REQ-033 sig_in high for 2 cycles then low -> no event; state returns to LOW; event_count=0.
REQ-034 evt_ready=0, rise then fall -> first event (type 1) held stable, fall dropped, ovf=1, event_count=1. Then ovf_clr=1 -> ovf=0.
REQ-035 CNT_W=2, 5 qualified edges with evt_ready=1 -> event_count saturates at 3.
REQ-036 Reset asserted mid-RISE_CHK with sig_in held high -> no event during reset. After release: rise event 6 edges later, event_count=1.
REQ-037 EDGE_TIMESTAMP_EN, TS_W=4, event in the cycle the counter reads 15 -> evt_ts=15; the next event timestamp reflects the wrap through 0.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the edge debounce/capture block.
package edge_pkg;

  // Debounce FSM states: settled low, qualifying a rise, settled high,
  // qualifying a fall.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } edge_state_e;

  // Event type encoding carried on evt_type.
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/edge_prev_sync.sv
// edge_prev_sync: two-stage register chain that brings the raw asynchronous
// input into the clock domain before the debounce FSM looks at it.
module edge_prev_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic sig_o
);

  logic p1Sig_q;
  logic p2Sig_q;

  // Shift the raw level through two flops; only the second stage is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1Sig_q <= 1'b0;
      p2Sig_q <= 1'b0;
    end else begin
      p1Sig_q <= sig_i;
      p2Sig_q <= p1Sig_q;
    end
  end

  assign sig_o = p2Sig_q;

endmodule

// File: rtl/edge_debounce_capture.sv
// edge_debounce_capture: debounces sig_in, turns each accepted level change
// into a rise/fall event and holds it in a one-deep valid/ready register,
// with a saturating event counter and a sticky overflow flag for events that
// arrive while the previous one is still pending.
// Optional feature: define EDGE_TIMESTAMP_EN to add a free-running TS_W-bit
// timestamp counter and the evt_ts output.
module edge_debounce_capture
  import edge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int TS_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_type,
`ifdef EDGE_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic [CNT_W-1:0] event_count,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic p2Sig;

  edge_state_e state_q, state_d;
  logic [7:0]  debCnt_q, debCnt_d;
  logic        evtPulse;
  logic        evtPulseType;

  logic             evtLoad;
  logic             evtDrop;
  logic             evtValid_q, evtValid_d;
  logic             evtType_q, evtType_d;
  logic [CNT_W-1:0] eventCount_q, eventCount_d;
  logic             ovf_q, ovf_d;

  edge_prev_sync uPrevSync (
    .clk   (clk),
    .reset (reset),
    .sig_i (sig_in),
    .sig_o (p2Sig)
  );

  // Debounce state and stability counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOW;
      debCnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      debCnt_q <= debCnt_d;
    end
  end

  // A level change is accepted once the synchronised input has disagreed with
  // the settled level for DEBOUNCE_CYCLES consecutive samples; the accepting
  // cycle produces a one-cycle event pulse.
  always_comb begin
    state_d      = state_q;
    debCnt_d     = debCnt_q;
    evtPulse     = 1'b0;
    evtPulseType = EDGE_FALL;
    unique case (state_q)
      LOW: begin
        if (p2Sig) begin
          state_d  = RISE_CHK;
          debCnt_d = 8'd1;
        end
      end
      RISE_CHK: begin
        if (!p2Sig) begin
          state_d  = LOW;
          debCnt_d = 8'd0;
        end else if (debCnt_q == DEB_LAST) begin
          state_d      = HIGH;
          debCnt_d     = 8'd0;
          evtPulse     = 1'b1;
          evtPulseType = EDGE_RISE;
        end else begin
          debCnt_d = debCnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (!p2Sig) begin
          state_d  = FALL_CHK;
          debCnt_d = 8'd1;
        end
      end
      FALL_CHK: begin
        if (p2Sig) begin
          state_d  = HIGH;
          debCnt_d = 8'd0;
        end else if (debCnt_q == DEB_LAST) begin
          state_d      = LOW;
          debCnt_d     = 8'd0;
          evtPulse     = 1'b1;
          evtPulseType = EDGE_FALL;
        end else begin
          debCnt_d = debCnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = LOW;
        debCnt_d = 8'd0;
      end
    endcase
  end

  // An event is taken when the holding register is empty or being emptied in
  // the same cycle; otherwise it is dropped and recorded in the sticky flag.
  assign evtLoad = evtPulse && (!evtValid_q || evt_ready);
  assign evtDrop = evtPulse && evtValid_q && !evt_ready;

  // Next state of the event holding register, counter and overflow flag.
  // A drop and a clear in the same cycle leave the flag set.
  always_comb begin
    evtValid_d   = evtValid_q;
    evtType_d    = evtType_q;
    eventCount_d = eventCount_q;
    ovf_d        = ovf_q;
    if (evtLoad) begin
      evtValid_d = 1'b1;
      evtType_d  = evtPulseType;
      if (eventCount_q != CNT_MAX) begin
        eventCount_d = eventCount_q + CNT_W'(1);
      end
    end else if (evt_ready) begin
      evtValid_d = 1'b0;
    end
    if (evtDrop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Event holding register, counter and overflow flag storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evtValid_q   <= 1'b0;
      evtType_q    <= EDGE_FALL;
      eventCount_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      evtValid_q   <= evtValid_d;
      evtType_q    <= evtType_d;
      eventCount_q <= eventCount_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt_valid   = evtValid_q;
  assign evt_type    = evtType_q;
  assign event_count = eventCount_q;
  assign ovf         = ovf_q;

`ifdef EDGE_TIMESTAMP_EN
  logic [TS_W-1:0] tsCnt_q;
  logic [TS_W-1:0] evtTs_q, evtTs_d;

  // Free-running timestamp; wraps naturally at 2^TS_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tsCnt_q <= '0;
    end else begin
      tsCnt_q <= tsCnt_q + TS_W'(1);
    end
  end

  // The stored timestamp follows the event register: it only changes when a
  // new event is actually loaded, so it stays stable while pending.
  always_comb begin
    evtTs_d = evtTs_q;
    if (evtLoad) begin
      evtTs_d = tsCnt_q;
    end
  end

  // Timestamp capture register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evtTs_q <= '0;
    end else begin
      evtTs_q <= evtTs_d;
    end
  end

  assign evt_ts = evtTs_q;
`else
  // TS_W only sizes evt_ts; this tie-off keeps the parameter referenced when
  // timestamps are compiled out.
  logic [TS_W-1:0] unusedTsWidth;
  assign unusedTsWidth = '0;
`endif

endmodule

// File: tb/tb_edge_debounce_capture.sv
// tb_edge_debounce_capture: drives two instances (default widths, and a
// 2-bit counter / 4-bit timestamp variant) with the same directed stimulus
// and compares both against a level/run-length model every cycle.
module tb_edge_debounce_capture;

  localparam int DEB = 4;

  logic clk;
  logic reset;
  logic sig_in;
  logic evt_ready;
  logic ovf_clr;

  logic       evtValidA, evtTypeA, ovfA;
  logic [7:0] countA;
  logic       evtValidB, evtTypeB, ovfB;
  logic [1:0] countB;
`ifdef EDGE_TIMESTAMP_EN
  logic [15:0] evtTsA;
  logic [3:0]  evtTsB;
`endif

  int checks = 0;
  int errors = 0;

  edge_debounce_capture #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8), .TS_W(16)) dutA (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .evt_valid   (evtValidA),
    .evt_ready   (evt_ready),
    .evt_type    (evtTypeA),
`ifdef EDGE_TIMESTAMP_EN
    .evt_ts      (evtTsA),
`endif
    .event_count (countA),
    .ovf         (ovfA),
    .ovf_clr     (ovf_clr)
  );

  edge_debounce_capture #(.DEBOUNCE_CYCLES(DEB), .CNT_W(2), .TS_W(4)) dutB (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .evt_valid   (evtValidB),
    .evt_ready   (evt_ready),
    .evt_type    (evtTypeB),
`ifdef EDGE_TIMESTAMP_EN
    .evt_ts      (evtTsB),
`endif
    .event_count (countB),
    .ovf         (ovfB),
    .ovf_clr     (ovf_clr)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: sampled input history, settled level, length of the current
  // disagreeing run, and the expected event register contents.
  bit sampleHist[$];
  bit mSeen    = 1'b0;
  bit mLevel   = 1'b0;
  int mRun     = 0;
  bit mEvt     = 1'b0;
  bit mValid   = 1'b0;
  bit mType    = 1'b0;
  bit mOvf     = 1'b0;
  int mCountA  = 0;
  int mCountB  = 0;
  int mTsCnt   = 0;
  int mTs      = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit rdy, input bit clr);
    sig_in    = s;
    evt_ready = rdy;
    ovf_clr   = clr;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected behaviour: the input seen two samples late must disagree with the
  // settled level for DEB consecutive edges to flip it; each flip is an event
  // that is taken if the register is free or being consumed, else dropped.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sampleHist.delete();
      mLevel  = 1'b0;
      mRun    = 0;
      mValid  = 1'b0;
      mType   = 1'b0;
      mOvf    = 1'b0;
      mCountA = 0;
      mCountB = 0;
      mTsCnt  = 0;
      mTs     = 0;
    end else begin
      mSeen = (sampleHist.size() == 2) ? sampleHist[0] : 1'b0;
      mEvt  = 1'b0;
      if (mSeen != mLevel) begin
        mRun++;
        if (mRun == DEB) begin
          mEvt   = 1'b1;
          mLevel = mSeen;
          mRun   = 0;
        end
      end else begin
        mRun = 0;
      end
      if (mEvt && mValid && !evt_ready) begin
        mOvf = 1'b1;
      end else begin
        if (ovf_clr) mOvf = 1'b0;
        if (mEvt) begin
          mValid  = 1'b1;
          mType   = mLevel;
          mTs     = mTsCnt;
          mCountA = (mCountA < 255) ? mCountA + 1 : 255;
          mCountB = (mCountB < 3) ? mCountB + 1 : 3;
        end else if (evt_ready) begin
          mValid = 1'b0;
        end
      end
      mTsCnt++;
      sampleHist.push_back(sig_in);
      if (sampleHist.size() > 2) void'(sampleHist.pop_front());
    end
  end

  // Every falling clock edge, both instances are held against the model.
  always @(negedge clk) begin
    checkOutput("validA", int'(evtValidA), int'(mValid));
    checkOutput("countA", int'(countA), mCountA);
    checkOutput("ovfA", int'(ovfA), int'(mOvf));
    checkOutput("validB", int'(evtValidB), int'(mValid));
    checkOutput("countB", int'(countB), mCountB);
    checkOutput("ovfB", int'(ovfB), int'(mOvf));
    if (mValid) begin
      checkOutput("typeA", int'(evtTypeA), int'(mType));
      checkOutput("typeB", int'(evtTypeB), int'(mType));
`ifdef EDGE_TIMESTAMP_EN
      checkOutput("tsA", int'(evtTsA), mTs & 16'hFFFF);
      checkOutput("tsB", int'(evtTsB), mTs & 4'hF);
`endif
    end
  end

  // Directed scenarios with hand-computed expectations at key cycles.
  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(3);
    checkOutput("resetValid", int'(evtValidA), 0);
    checkOutput("resetCount", int'(countA), 0);
    checkOutput("resetOvf", int'(ovfA), 0);
    checkOutput("resetType", int'(evtTypeA), 0);
    reset = 1'b1;
    waitEdges(2);

    // Clean rise with the consumer always ready.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(5);
    checkOutput("riseEarly", int'(evtValidA), 0);
    waitEdges(1);
    checkOutput("riseValid", int'(evtValidA), 1);
    checkOutput("riseType", int'(evtTypeA), 1);
    checkOutput("riseCount", int'(countA), 1);
    waitEdges(1);
    checkOutput("riseConsumed", int'(evtValidA), 0);

    // Clean fall.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(8);
    checkOutput("fallCount", int'(countA), 2);

    // Two-cycle glitch is rejected.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(10);
    checkOutput("glitchCount", int'(countA), 2);
    checkOutput("glitchValid", int'(evtValidA), 0);

    // Consumer stalled: rise held, following fall dropped.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(8);
    checkOutput("heldValid", int'(evtValidA), 1);
    checkOutput("heldType", int'(evtTypeA), 1);
    checkOutput("heldCountA", int'(countA), 3);
    checkOutput("heldCountB", int'(countB), 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(8);
    checkOutput("dropType", int'(evtTypeA), 1);
    checkOutput("dropOvf", int'(ovfA), 1);
    checkOutput("dropCount", int'(countA), 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitEdges(1);
    checkOutput("ovfCleared", int'(ovfA), 0);

    // Drop while clear is held: set wins, then clear takes effect.
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitEdges(6);
    checkOutput("setWins", int'(ovfA), 1);
    waitEdges(1);
    checkOutput("clearAfterSet", int'(ovfA), 0);

    // Fall arrives in the same cycle the pending rise is accepted.
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(5);
    checkOutput("preHandshakeType", int'(evtTypeA), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(1);
    checkOutput("swapValid", int'(evtValidA), 1);
    checkOutput("swapType", int'(evtTypeA), 0);
    checkOutput("swapCountA", int'(countA), 4);
    checkOutput("swapCountB", int'(countB), 3);
    waitEdges(1);
    checkOutput("swapConsumed", int'(evtValidA), 0);

    // Narrow counter stays saturated.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(8);
    checkOutput("satCountA", int'(countA), 5);
    checkOutput("satCountB", int'(countB), 3);

    // Reset in the middle of a rise qualification.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(8);
    checkOutput("preResetCount", int'(countA), 6);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(4);
    reset = 1'b0;
    waitEdges(2);
    checkOutput("midResetValid", int'(evtValidA), 0);
    checkOutput("midResetCount", int'(countA), 0);
    reset = 1'b1;
    waitEdges(5);
    checkOutput("requalEarly", int'(evtValidA), 0);
    waitEdges(1);
    checkOutput("requalValid", int'(evtValidA), 1);
    checkOutput("requalType", int'(evtTypeA), 1);
    checkOutput("requalCount", int'(countA), 1);
`ifdef EDGE_TIMESTAMP_EN
    checkOutput("requalTsA", int'(evtTsA), 5);
    checkOutput("requalTsB", int'(evtTsB), 5);
`endif

    // Events timed around the 4-bit timestamp wrap.
    waitEdges(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(6);
    checkOutput("wrapFallValid", int'(evtValidA), 1);
    checkOutput("wrapFallType", int'(evtTypeA), 0);
`ifdef EDGE_TIMESTAMP_EN
    checkOutput("ts15A", int'(evtTsA), 15);
    checkOutput("ts15B", int'(evtTsB), 15);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(6);
    checkOutput("wrapRiseValid", int'(evtValidA), 1);
    checkOutput("wrapRiseType", int'(evtTypeA), 1);
    checkOutput("wrapCount", int'(countA), 3);
`ifdef EDGE_TIMESTAMP_EN
    checkOutput("tsWrapA", int'(evtTsA), 21);
    checkOutput("tsWrapB", int'(evtTsB), 5);
`endif
    waitEdges(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
